// File: rtl/mantenimiento_scheduler_pkg.sv
// mantenimiento_pkg: scheduler state encoding, FSM idle code and saturating counter helper
package mantenimiento_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ESPERA, S_INICIAR, S_ACTIVO, S_DETENER, S_DRENAR, S_ERROR} sched_state_t;
  localparam logic [7:0] ESTADO_IDLE = 8'h00;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v == 8'hff ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/mantenimiento_scheduler_timer.sv
// mant_timer: loadable down-counter; expired while the count is at its last cycle (or idle at zero)
module mant_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
  assign expired_o = cnt_q <= W'(1);
endmodule

// File: rtl/mantenimiento_scheduler.sv
// mantenimiento_scheduler: periodic/manual starter for the maintenance FSM with timeout abort, bounded retry and count cross-check
module mantenimiento_scheduler
  import mantenimiento_pkg::*;
#(
  parameter int INTERVAL_W  = 16,
  parameter int MAX_RETRIES = 2,
  parameter int DRAIN_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  habilitar,
  input  logic [INTERVAL_W-1:0] intervalo,
  input  logic [INTERVAL_W-1:0] timeout,
  input  logic                  solicitud_manual,
  input  logic                  terminado,
  input  logic [7:0]            estado_fsm,
  input  logic [7:0]            num_mantenimientos,
  output logic                  iniciar,
  output logic                  detener,
  output logic                  ocupado,
  output logic [7:0]            cnt_ok,
  output logic [7:0]            cnt_timeout,
  output logic                  error,
  output logic [2:0]            estado_sched
);
  sched_state_t state_q, state_d;
  logic [7:0] retries_q, retries_d, expected_q, expected_d;
  logic [7:0] cnt_ok_q, cnt_ok_d, cnt_to_q, cnt_to_d;
  logic iniciar_q, detener_q, ocupado_q, error_q, mismatch, expired, load;
  logic [INTERVAL_W-1:0] load_val;
  // One timer serves every timed phase; it is reloaded whenever one of them is entered
  assign load = state_d != state_q && (state_d == S_ESPERA || state_d == S_ACTIVO || state_d == S_DRENAR);
  assign load_val = state_d == S_ESPERA ? (intervalo == '0 ? INTERVAL_W'(1) : intervalo) :
                    state_d == S_ACTIVO ? (timeout == '0 ? INTERVAL_W'(1) : timeout) :
                    INTERVAL_W'(DRAIN_CYC);
  mant_timer #(.W(INTERVAL_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .val_i     (load_val),
    .expired_o (expired)
  );
  always_comb begin
    state_d    = state_q;
    retries_d  = retries_q;
    expected_d = expected_q;
    cnt_ok_d   = cnt_ok_q;
    cnt_to_d   = cnt_to_q;
    mismatch   = 1'b0;
    case (state_q)
      S_IDLE:    state_d = habilitar ? S_ESPERA : S_IDLE;
      S_ESPERA:  state_d = !habilitar ? S_IDLE : (solicitud_manual || expired) ? S_INICIAR : S_ESPERA;
      S_INICIAR: state_d = S_ACTIVO;
      S_ACTIVO:
        if (terminado) begin
          cnt_ok_d   = sat_inc(cnt_ok_q);
          expected_d = expected_q + 8'd1;
          retries_d  = '0;
          mismatch   = num_mantenimientos != expected_d;
          state_d    = habilitar ? S_ESPERA : S_IDLE;
        end else if (expired) state_d = S_DETENER;
      S_DETENER: begin
        cnt_to_d = sat_inc(cnt_to_q);
        state_d  = S_DRENAR;
      end
      S_DRENAR:
        if (estado_fsm == ESTADO_IDLE) begin
          retries_d = retries_q < 8'(MAX_RETRIES) ? retries_q + 8'd1 : retries_q;
          state_d   = retries_q < 8'(MAX_RETRIES) ? S_INICIAR : S_ERROR;
        end else if (expired) state_d = S_ERROR;
      default:   state_d = S_ERROR;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= S_IDLE;
      retries_q  <= '0;
      expected_q <= '0;
      cnt_ok_q   <= '0;
      cnt_to_q   <= '0;
      iniciar_q  <= 1'b0;
      detener_q  <= 1'b0;
      ocupado_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      retries_q  <= retries_d;
      expected_q <= expected_d;
      cnt_ok_q   <= cnt_ok_d;
      cnt_to_q   <= cnt_to_d;
      iniciar_q  <= state_d == S_INICIAR;
      detener_q  <= state_d == S_DETENER;
      ocupado_q  <= state_d == S_INICIAR || state_d == S_ACTIVO || state_d == S_DETENER || state_d == S_DRENAR;
      error_q    <= error_q || mismatch || state_d == S_ERROR;
    end
  assign iniciar      = iniciar_q;
  assign detener      = detener_q;
  assign ocupado      = ocupado_q;
  assign cnt_ok       = cnt_ok_q;
  assign cnt_timeout  = cnt_to_q;
  assign error        = error_q;
  assign estado_sched = state_q;
endmodule
